// File: rtl/btn_debounce_pkg.sv
// Shared defaults for the button/switch debouncer and its per-bit slice.
package btn_debounce_pkg;

    // 4 buttons + 8 slide switches on the board.
    localparam int NIN_DEF          = 12;
    // Consecutive differing sample ticks needed before a new level is accepted.
    localparam int STABLE_TICKS_DEF = 8;

    // Board tick-rate selection: the sample tick is derived from the system
    // clock by this divider (100 MHz / 1 kHz).
    localparam int CLK_HZ_DEF       = 100_000_000;
    localparam int TICK_HZ_DEF      = 1_000;
    localparam int TICK_DIV_DEF     = CLK_HZ_DEF / TICK_HZ_DEF;

    // Counter width able to hold 0..ticks.
    function automatic int cnt_width(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One debounced input: synchronizer, stability counter, edge pulses and
// sticky event flags.
module btn_debounce_bit
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
)(
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    input  logic clr,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic pressed,
    output logic released
);

    localparam int            CW   = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;

    // Next-state: count differing ticks, flip the level on the last one; edges
    // are taken from the registered level so they trail the change by one clk.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (tick) begin
            if (sync_q[1] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                stable_d = sync_q[1];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d     = stable_q & ~prev_q;
        fall_d     = ~stable_q & prev_q;
        // A new event beats a simultaneous clear.
        pressed_d  = rise_q | (pressed_q & ~clr);
        released_d = fall_q | (released_q & ~clr);
    end

    // State registers with synchronous reset; the synchronizer runs every clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= 1'b0;
            prev_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], raw};
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            prev_q     <= stable_q;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign stable   = stable_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign pressed  = pressed_q;
    assign released = released_q;

endmodule

// File: rtl/btn_debounce.sv
// Debouncer for NIN independent board inputs with a shared event interrupt.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NIN          = NIN_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [NIN-1:0] raw,
    input  logic [NIN-1:0] clr,
    output logic [NIN-1:0] stable,
    output logic [NIN-1:0] rise,
    output logic [NIN-1:0] fall,
    output logic [NIN-1:0] pressed,
    output logic [NIN-1:0] released,
    output logic           irq
);

    for (genvar g = 0; g < NIN; g++) begin : g_bit
        btn_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .raw      (raw[g]),
            .clr      (clr[g]),
            .stable   (stable[g]),
            .rise     (rise[g]),
            .fall     (fall[g]),
            .pressed  (pressed[g]),
            .released (released[g])
        );
    end

    // Interrupt whenever any sticky flag is pending; no extra register stage.
    always_comb begin
        irq = (|pressed) | (|released);
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter NIN, default 12, number of independent inputs (4 buttons + 8 switches).
REQ-002 Parameter STABLE_TICKS, default 8, consecutive differing sample ticks required to accept a new level; legal range 1..255.
REQ-003 clk  input  1  system clock; all state on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  sample enable, one clk wide (e.g. from f1kHz edge detect); may be held high.
REQ-006 raw  input  NIN  asynchronous board inputs (BTN/SW pins).
REQ-007 clr  input  NIN  per-bit clear of sticky event flags, level, sampled each clk.
REQ-008 stable  output  NIN  debounced level, registered.
REQ-009 rise  output  NIN  one-clk pulse on stable 0->1, registered.
REQ-010 fall  output  NIN  one-clk pulse on stable 1->0, registered.
REQ-011 pressed  output  NIN  sticky flag, set by rise, cleared by clr.
REQ-012 released  output  NIN  sticky flag, set by fall, cleared by clr.
REQ-013 irq  output  1  OR of all pressed and released bits.

Function
REQ-014 Each raw bit passes a 2-flop synchronizer clocked every clk; sync = raw delayed 2 clk; tick does not gate it.
REQ-015 Each bit owns a counter cnt of width ceil(log2(STABLE_TICKS+1)).
REQ-016 Cycles with tick=0: cnt, stable hold.
REQ-017 Tick with sync==stable: cnt <= 0.
REQ-018 Tick with sync!=stable and cnt < STABLE_TICKS-1: cnt <= cnt+1.
REQ-019 Tick with sync!=stable and cnt == STABLE_TICKS-1: stable <= sync, cnt <= 0.
REQ-020 Net effect: stable changes on the STABLE_TICKS-th consecutive tick at which sync differs; any agreeing tick restarts the count.
REQ-021 rise/fall asserted in the clk cycle after stable changes, for exactly one clk; never both on one bit.
REQ-022 pressed[i] set on rise[i]; released[i] set on fall[i]; clear only when clr[i]=1.
REQ-023 Set and clr in same cycle: set wins, flag stays 1.
REQ-024 clr held high: flag still set by a new event (per REQ-023), cleared the following cycle if clr persists.
REQ-025 irq is combinational OR of registered pressed/released; no further latency.
REQ-026 Bits fully independent; simultaneous events on multiple bits all reported in the same cycle.
REQ-027 STABLE_TICKS=1: stable follows sync on the first differing tick.
REQ-028 Latency, tick held high: raw edge at cycle 0 -> stable change at cycle 2+STABLE_TICKS -> rise/fall at cycle 3+STABLE_TICKS.

Reset
REQ-029 reset=1 at posedge clk: synchronizer flops, cnt, stable, rise, fall, pressed, released all <= 0; irq therefore 0.
REQ-030 Reset mid-count discards progress; after release a full STABLE_TICKS run is required.
REQ-031 First posedge after reset deasserts behaves normally; a switch held high after reset reaches stable=1 and generates rise/pressed.

Structure
REQ-032 Default NIN and STABLE_TICKS values and the board tick-rate selection constant live in the shared defs.v.
REQ-033 Per-bit logic (synchronizer, counter, stable, edge, sticky flags) is sub-module debounce_bit, instantiated NIN times by generate; btn_debounce adds only irq.

Verification (NIN=4, STABLE_TICKS=4, tick every 10 clk unless stated)
REQ-034 Clean edge: raw[0] 0->1 and held -> stable[0]=1 after 4th tick following sync, rise[0] 1 clk, pressed[0]=1, irq=1.
REQ-035 Bounce: raw[1] toggles every 15 clk for 120 clk then held 1 -> no stable[1] change during bounce; single rise[1] after 4 quiet ticks.
REQ-036 Clear race: clr[0]=1 in exact cycle rise[0]=1 -> pressed[0] stays 1; clr[0] next cycle -> pressed[0]=0, irq=0.
REQ-037 Reset mid-count: raw[2]=1, reset pulsed after 3 ticks -> all outputs 0; stable[2] rises only after 4 further ticks.
REQ-038 STABLE_TICKS=1, tick=1 constant: raw[3] 0->1 at cycle 0 -> stable[3]=1 at cycle 3, rise[3] at cycle 4.
REQ-039 Simultaneous: raw=4'b1111 at once -> rise=4'b1111 in one cycle; later raw=0 -> fall=4'b1111, released=4'b1111.
